// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser -- serial-in / parallel-out deserialiser with a one-deep frame
// holding register and a valid/ready hand-off to the consumer.
//
// Bits arriving on serial_in (qualified by shift_en) are shifted into a
// WIDTH-bit register. When the WIDTH-th bit of a frame is accepted, the
// post-shift register value is snapshotted into frame_data and frame_valid
// rises on the following cycle. If a new frame completes while the previous
// one is still unconsumed, it is overwritten and the sticky overrun flag sets.
//
// Parameters
//   WIDTH      frame length in bits (2..32)
//   MSB_FIRST  1: first received bit ends up in bit WIDTH-1
//              0: first received bit ends up in bit 0
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (highest priority)
//   serial_in    serial data bit, sampled when shift_en=1
//   shift_en     accept serial_in this cycle; 0 holds the shift state
//   clear        synchronous flush of partial frame, frame_valid and overrun
//   frame_ready  consumer accepts frame_data while frame_valid=1
//   parallel_out live shift-register contents
//   bit_count    bits received in the current partial frame (0..WIDTH-1)
//   frame_data   last completed frame
//   frame_valid  frame_data holds an unconsumed frame
//   overrun      sticky: a frame was overwritten before being consumed
//
// Handshake: a frame transfers on every rising edge where frame_valid=1 and
// frame_ready=1. While frame_valid=1 and no transfer has happened, frame_data
// is held stable unless a newer frame completes (which overwrites it and
// flags overrun). frame_ready while frame_valid=0 is ignored.
// -----------------------------------------------------------------------------
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = (WIDTH <= 2) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic [CNT_W-1:0] bit_count,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] frame_q;
  logic             valid_q;
  logic             overrun_q;

  logic [WIDTH-1:0] sr_next;
  logic             frame_done;
  logic             consume;
  logic             lost_frame;

  always_comb begin
    sr_next = sr_q;
    if (MSB_FIRST) begin
      sr_next = {sr_q[WIDTH-2:0], serial_in};
    end else begin
      sr_next = {serial_in, sr_q[WIDTH-1:1]};
    end
  end

  // A frame completes on the accepted bit that finds the counter at its
  // last value; the counter wraps on that same edge so the next bit starts
  // a fresh frame with no dead cycle.
  assign frame_done = shift_en && (cnt_q == LAST_BIT);
  assign consume    = valid_q && frame_ready;
  // Overwriting an unconsumed frame loses data; a same-edge consume does not.
  assign lost_frame = frame_done && valid_q && !frame_ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (shift_en) begin
        sr_q  <= sr_next;
        cnt_q <= frame_done ? '0 : (cnt_q + CNT_ONE);
      end

      if (frame_done) begin
        frame_q <= sr_next;
        valid_q <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end

      if (lost_frame) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign parallel_out = sr_q;
  assign bit_count    = cnt_q;
  assign frame_data   = frame_q;
  assign frame_valid  = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser -- self-checking bench for sipo_deser.
// Two instances (WIDTH=4, MSB-first and LSB-first) share all inputs. A
// bit-history model derives expected outputs each cycle; directed sequences
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sipo_deser;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear, serial_in, shift_en, frame_ready;

  logic [W-1:0] po_m, fd_m, po_l, fd_l;
  logic [1:0]   bc_m, bc_l;
  logic         fv_m, fv_l, ov_m, ov_l;

  int tests = 0;
  int fails = 0;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
    .clear(clear), .frame_ready(frame_ready), .parallel_out(po_m),
    .bit_count(bc_m), .frame_data(fd_m), .frame_valid(fv_m), .overrun(ov_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
    .clear(clear), .frame_ready(frame_ready), .parallel_out(po_l),
    .bit_count(bc_l), .frame_data(fd_l), .frame_valid(fv_l), .overrun(ov_l)
  );

  // ---------------- model ----------------
  // hist holds the accepted bits since the last flush (oldest first, at
  // most W). Frame fill level, valid and overrun follow the stated rules.
  bit           hist[$];
  int           m_cnt = 0;
  logic [W-1:0] m_fd_m = '0, m_fd_l = '0;
  logic         m_fv = 1'b0, m_ov = 1'b0;
  bit           m_live = 1'b0;
  bit           m_done;

  function automatic logic [W-1:0] sr_of(input bit msb);
    logic [W-1:0] v;
    int n;
    v = '0;
    n = hist.size();
    for (int i = 0; i < n; i++) begin
      if (hist[i]) begin
        if (msb) v[n-1-i] = 1'b1;
        else     v[W-n+i] = 1'b1;
      end
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst || clear) begin
      hist.delete();
      m_cnt  = 0;
      m_fd_m = '0;
      m_fd_l = '0;
      m_fv   = 1'b0;
      m_ov   = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_done = 1'b0;
      if (shift_en) begin
        hist.push_back(serial_in);
        if (hist.size() > W) void'(hist.pop_front());
        m_cnt++;
        if (m_cnt == W) begin
          m_cnt  = 0;
          m_done = 1'b1;
        end
      end
      if (m_done) begin
        if (m_fv && !frame_ready) m_ov = 1'b1;
        m_fv   = 1'b1;
        m_fd_m = sr_of(1'b1);
        m_fd_l = sr_of(1'b0);
      end else if (m_fv && frame_ready) begin
        m_fv = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_po_msb", 32'(po_m), 32'(sr_of(1'b1)));
      chk("model_po_lsb", 32'(po_l), 32'(sr_of(1'b0)));
      chk("model_bc_msb", 32'(bc_m), 32'(m_cnt));
      chk("model_bc_lsb", 32'(bc_l), 32'(m_cnt));
      chk("model_fd_msb", 32'(fd_m), 32'(m_fd_m));
      chk("model_fd_lsb", 32'(fd_l), 32'(m_fd_l));
      chk("model_fv_msb", 32'(fv_m), 32'(m_fv));
      chk("model_fv_lsb", 32'(fv_l), 32'(m_fv));
      chk("model_ov_msb", 32'(ov_m), 32'(m_ov));
      chk("model_ov_lsb", 32'(ov_l), 32'(m_ov));
    end
  end

  // ---------------- drivers ----------------
  // Called right after a falling edge: drives inputs, lets one rising edge
  // apply them, returns at the next falling edge.
  task automatic cyc(input logic r, input logic c, input logic e, input logic s, input logic y);
    rst = r; clear = c; shift_en = e; serial_in = s; frame_ready = y;
    @(negedge clk);
  endtask

  // Sends bits[n-1] first down to bits[0].
  task automatic shift_bits(input logic [7:0] bits, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b0, 1'b1, bits[i], rdy);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_po"}, 32'(po_m), 32'd0);
    chk({tag, "_bc"}, 32'(bc_m), 32'd0);
    chk({tag, "_fd"}, 32'(fd_m), 32'd0);
    chk({tag, "_fv"}, 32'(fv_m), 32'd0);
    chk({tag, "_ov"}, 32'(ov_m), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; shift_en = 1'b0; serial_in = 1'b0; frame_ready = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Basic frame 1,0,1,1 with no consumer
    shift_bits(8'b101, 3, 1'b0);
    chk("pre_done_fv", 32'(fv_m), 32'd0);
    chk("pre_done_bc", 32'(bc_m), 32'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("f1_fd_msb", 32'(fd_m), 32'b1011);
    chk("f1_fv", 32'(fv_m), 32'd1);
    chk("f1_bc", 32'(bc_m), 32'd0);
    chk("f1_po_lsb", 32'(po_l), 32'b1101);
    chk("f1_fd_lsb", 32'(fd_l), 32'b1101);

    // Consume
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("consume_fv", 32'(fv_m), 32'd0);
    chk("consume_fd_hold", 32'(fd_m), 32'b1011);

    // Back-to-back frames without consumer -> overrun
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'b10110110, 8, 1'b0);
    chk("b2b_fd", 32'(fd_m), 32'b0110);
    chk("b2b_ov", 32'(ov_m), 32'd1);
    chk("b2b_fv", 32'(fv_m), 32'd1);
    chk("b2b_fd_lsb", 32'(fd_l), 32'b0110);
    // frame_ready does not clear overrun
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ov_sticky_fv", 32'(fv_m), 32'd0);
    chk("ov_sticky_ov", 32'(ov_m), 32'd1);

    // Same-edge consume and completion -> no overrun
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clear_ov", 32'(ov_m), 32'd0);
    shift_bits(8'b1011011, 7, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("same_edge_fv", 32'(fv_m), 32'd1);
    chk("same_edge_ov", 32'(ov_m), 32'd0);
    chk("same_edge_fd", 32'(fd_m), 32'b0110);

    // Clear mid-frame discards the presented bit
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'b11, 2, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_bc", 32'(bc_m), 32'd0);
    chk("clr_po", 32'(po_m), 32'd0);
    chk("clr_fv", 32'(fv_m), 32'd0);
    shift_bits(8'b0111, 4, 1'b0);
    chk("post_clr_fd_msb", 32'(fd_m), 32'b0111);
    chk("post_clr_fd_lsb", 32'(fd_l), 32'b1110);
    chk("post_clr_fv", 32'(fv_m), 32'd1);

    // Reset with valid, overrun and a partial frame
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_bits(8'b11001010, 8, 1'b0);
    shift_bits(8'b10, 2, 1'b0);
    chk("pre_rst_bc", 32'(bc_m), 32'd2);
    chk("pre_rst_ov", 32'(ov_m), 32'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_all_zero("rst_mid");

    // Reset mid-frame: next bit starts a new frame
    shift_bits(8'b11, 2, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_all_zero("rst_prio");
    shift_bits(8'b1001, 4, 1'b0);
    chk("rst_new_fd_msb", 32'(fd_m), 32'b1001);
    chk("rst_new_fv", 32'(fv_m), 32'd1);

    // shift_en toggling; disabled cycles present a different bit
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tog_bc1", 32'(bc_m), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tog_bc2", 32'(bc_m), 32'd2);
    chk("tog_po_msb", 32'(po_m), 32'b0011);
    chk("tog_po_lsb", 32'(po_l), 32'b1100);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tog_bc3", 32'(bc_m), 32'd3);
    chk("tog_fv_early", 32'(fv_m), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tog_fv", 32'(fv_m), 32'd1);
    chk("tog_fd_msb", 32'(fd_m), 32'b1101);
    chk("tog_fd_lsb", 32'(fd_l), 32'b1011);

    // Continuous stream with consumer always ready: one frame per W cycles
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1, (i % 3) == 0, 1'b1);
    chk("stream_fd_msb", 32'(fd_m), 32'b0100);
    chk("stream_fd_lsb", 32'(fd_l), 32'b0010);
    chk("stream_fv", 32'(fv_m), 32'd1);
    chk("stream_ov", 32'(ov_m), 32'd0);
    chk("stream_bc", 32'(bc_m), 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8: frame length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first received bit lands in bit WIDTH-1; 0 = first received bit lands in bit 0.
REQ-003 Derived constant CNT_W SHALL equal $clog2(WIDTH), with a minimum of 1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 serial_in  input  1  serial data bit, sampled when shift_en=1.
REQ-007 shift_en  input  1  qualifies serial_in; 0 = hold all shift state.
REQ-008 clear  input  1  synchronous flush of the partial frame, valid and overrun.
REQ-009 frame_ready  input  1  consumer accepts frame_data while frame_valid=1.
REQ-010 parallel_out  output  WIDTH  live shift-register contents, registered.
REQ-011 bit_count  output  CNT_W  bits received in the current partial frame.
REQ-012 frame_data  output  WIDTH  last completed frame, registered snapshot.
REQ-013 frame_valid  output  1  frame_data holds an unconsumed frame.
REQ-014 overrun  output  1  sticky flag: a frame was overwritten before it was consumed.

Function
REQ-015 When shift_en=1 and MSB_FIRST=1, the shift register SHALL update to {sr[WIDTH-2:0], serial_in}.
REQ-016 When shift_en=1 and MSB_FIRST=0, the shift register SHALL update to {serial_in, sr[WIDTH-1:1]}.
REQ-017 When shift_en=0, the shift register and bit_count SHALL hold.
REQ-018 bit_count SHALL increment by 1 per accepted bit and wrap from WIDTH-1 to 0; it SHALL never present values of WIDTH or above.
REQ-019 Frame completion is an accepted bit with bit_count=WIDTH-1; on that edge frame_data SHALL load the post-shift register value and frame_valid SHALL be set to 1.
REQ-020 Frame completion latency: frame_valid=1 and frame_data SHALL be visible in the cycle after the edge that samples the WIDTH-th bit.
REQ-021 Handshake: frame_valid SHALL stay 1 and frame_data stable until an edge where frame_valid=1 and frame_ready=1; frame_valid SHALL then clear.
REQ-022 Consume and new completion on the same edge: frame_valid SHALL remain 1, frame_data SHALL take the new frame, and overrun SHALL NOT set.
REQ-023 Completion while frame_valid=1 and frame_ready=0: frame_data SHALL be overwritten with the new frame, frame_valid SHALL stay 1, and overrun SHALL set.
REQ-024 overrun SHALL be cleared only by rst or clear; frame_ready SHALL have no effect on it.
REQ-025 frame_ready while frame_valid=0 SHALL have no effect.
REQ-026 clear=1 SHALL zero the shift register, bit_count, frame_data, frame_valid and overrun on that edge, overriding shift_en and frame_ready; the bit presented on that edge SHALL be discarded.
REQ-027 Continuous shift_en=1 SHALL complete one frame every WIDTH cycles with no dead cycle between frames.

Reset
REQ-028 rst=1 SHALL, on the clock edge, force parallel_out=0, bit_count=0, frame_data=0, frame_valid=0 and overrun=0.
REQ-029 rst SHALL take priority over clear, shift_en and frame_ready.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the next accepted bit SHALL be bit 0 of a new frame.
REQ-031 The block SHALL contain no asynchronous reset path.

Verification
REQ-032 Case: WIDTH=4, MSB_FIRST=1, serial 1,0,1,1 with shift_en=1 and frame_ready=0 -> frame_data=4'b1011, frame_valid=1 one cycle after the 4th bit, bit_count=0.
REQ-033 Case: WIDTH=4, MSB_FIRST=0, same serial bits -> parallel_out and frame_data=4'b1101.
REQ-034 Case: two back-to-back frames 1011 then 0110, frame_ready=0 -> frame_data=4'b0110, overrun=1. Repeat with frame_ready=1 on the 8th bit edge -> overrun=0, frame_valid=1.
REQ-035 Case: 2 bits shifted, then clear=1 with shift_en=1 -> bit_count=0, parallel_out=0; the following 4 bits form a complete frame.
REQ-036 Case: rst asserted with frame_valid=1, overrun=1 and bit_count=2 -> all outputs 0 on the next cycle.
REQ-037 Case: shift_en toggling 1,0,1,0 over 8 cycles -> bit_count advances only on enabled cycles; the frame completes after the 4th enabled bit.
